// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings, FSM states
// and the access-size decode.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCESS,
    S_SPLIT,
    S_RESP
  } lsu_state_t;

  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Builds the final load value from four assembled bytes: sign or zero extension
// selected by the load funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_LB:   result = {{24{raw[7]}}, raw[7:0]};
      F3_LH:   result = {{16{raw[15]}}, raw[15:0]};
      F3_LBU:  result = {24'd0, raw[7:0]};
      F3_LHU:  result = {16'd0, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer in front of data_memory. Define
// LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of splitting them.
//
// state    | meaning
// IDLE     | ready for a request
// CHECK    | funct3 / range / alignment check
// ACCESS   | single aligned data_memory access
// SPLIT    | one byte beat per cycle for a misaligned access
// RESP     | one-cycle response pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        state, state_nx;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, result_q;

  logic [2:0]        size;
  logic [ADDR_W:0]   last_byte;
  logic              f3_bad, range_bad, misal, check_err;

  always_comb begin
    size      = access_size(f3_q);
    f3_bad    = we_q ? !(f3_q inside {F3_SB, F3_SH, F3_SW})
                     : !(f3_q inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    // one extra bit so a request near the top of the address space cannot wrap
    last_byte = {1'b0, addr_q} + (ADDR_W+1)'(size) - (ADDR_W+1)'(1);
    range_bad = last_byte >= (ADDR_W+1)'(MEM_BYTES);
    misal     = (size == 3'd2) ? addr_q[0] :
                (size == 3'd4) ? (addr_q[1:0] != 2'b00) : 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    check_err = f3_bad | range_bad | misal;
`else
    check_err = f3_bad | range_bad;
`endif
  end

`ifndef LSU_MISALIGN_TRAP_EN
  logic [1:0]  beat_q;
  logic [31:0] asm_q, asm_nx, ext_out;
  logic        last_beat;

  always_comb begin
    asm_nx = asm_q;
    asm_nx[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
    last_beat = ({1'b0, beat_q} == (size - 3'd1));
  end

  lsu_load_extend u_load_extend (
    .funct3 (f3_q),
    .raw    (asm_nx),
    .result (ext_out)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      f3_q     <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      result_q <= 32'd0;
`ifndef LSU_MISALIGN_TRAP_EN
      beat_q   <= 2'd0;
      asm_q    <= 32'd0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
        end
        S_CHECK: begin
          err_q    <= check_err;
          result_q <= 32'd0;
`ifndef LSU_MISALIGN_TRAP_EN
          beat_q   <= 2'd0;
          asm_q    <= 32'd0;
`endif
        end
        // data_memory already extends aligned loads
        S_ACCESS: result_q <= we_q ? 32'd0 : mem_rdata;
`ifndef LSU_MISALIGN_TRAP_EN
        S_SPLIT: begin
          beat_q <= beat_q + 2'd1;
          asm_q  <= asm_nx;
          if (last_beat && !we_q) result_q <= ext_out;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'd0;
    mem_funct3 = 3'd0;
    case (state)
      S_IDLE: if (req_valid && !rst) state_nx = S_CHECK;
      S_CHECK: begin
        if (check_err)  state_nx = S_RESP;
`ifndef LSU_MISALIGN_TRAP_EN
        else if (misal) state_nx = S_SPLIT;
`endif
        else            state_nx = S_ACCESS;
      end
      // strobes are held off while rst is high so an aborted beat writes nothing
      S_ACCESS: begin
        mem_addr   = addr_q;
        mem_funct3 = f3_q;
        mem_wdata  = wdata_q;
        mem_read   = !we_q && !rst;
        mem_write  = we_q && !rst;
        state_nx   = S_RESP;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      S_SPLIT: begin
        mem_addr   = addr_q + ADDR_W'(beat_q);
        mem_funct3 = we_q ? F3_SB : F3_LBU;
        mem_wdata  = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
        mem_read   = !we_q && !rst;
        mem_write  = we_q && !rst;
        if (last_beat) state_nx = S_RESP;
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = result_q;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
